// File: rtl/fifo_cdc_pkg.sv
// Gray/binary helpers and pointer typedef shared by the CDC FIFO write and read pointer blocks.
// Pure combinational functions; no latency, no flow control.
package fifo_cdc_pkg;

    localparam int PTR_MAX_W              = 32;
    localparam int DEFAULT_NUM_ADDRESS    = 8;
    localparam int DEFAULT_POINTER_LENGTH = $clog2(DEFAULT_NUM_ADDRESS) + 1;

    typedef logic [DEFAULT_POINTER_LENGTH-1:0] ptr_t;

    function automatic logic [PTR_MAX_W-1:0] width_mask(input int width);
        logic [PTR_MAX_W-1:0] one;
        one = {{(PTR_MAX_W-1){1'b0}}, 1'b1};
        if (width >= PTR_MAX_W) begin
            return '1;
        end
        return (one << width) - one;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b,
                                                      input int width);
        logic [PTR_MAX_W-1:0] v;
        v = b & width_mask(width);
        return v ^ (v >> 1);
    endfunction

    // Bits above width are cleared first, so the prefix XOR starts from a zero MSB.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g,
                                                      input int width);
        logic [PTR_MAX_W-1:0] b;
        b = g & width_mask(width);
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ b[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_pointer.sv
// Binary/Gray pointer register pair with increment enable; shared by both FIFO sides.
// Registers update one edge after increment; next values are combinational; no backpressure.
module fifo_gray_pointer
    import fifo_cdc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             increment,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin_next,
    output logic [WIDTH-1:0] gray_next
);

    always_comb begin
        bin_next  = bin + WIDTH'(increment);
        gray_next = WIDTH'(bin2gray(PTR_MAX_W'(bin_next), WIDTH));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/fifo_write_pointer_full.sv
// Write-side pointers, full flag, occupancy and sticky overflow for the CDC FIFO; optional almost_full via FIFO_ALMOST_FULL_EN.
// Outputs registered on the accepting edge; writes are refused (write_accept=0) while fifo_full.
module fifo_write_pointer_full
    import fifo_cdc_pkg::*;
#(
    parameter int NUM_ADDRESS           = 8,
    parameter int ALMOST_FULL_THRESHOLD = 6,
    localparam int ADDR_WIDTH           = $clog2(NUM_ADDRESS),
    localparam int POINTER_LENGTH       = ADDR_WIDTH + 1
) (
    input  logic                      write_clk,
    input  logic                      write_reset_n,
    input  logic                      write_enable,
    input  logic [POINTER_LENGTH-1:0] read_pointer_sync,
    output logic [POINTER_LENGTH-1:0] write_pointer,
    output logic [ADDR_WIDTH-1:0]     write_address,
    output logic                      write_accept,
    output logic                      fifo_full,
    output logic [POINTER_LENGTH-1:0] write_level,
    output logic                      overflow
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic                      almost_full
`endif
);

    if (NUM_ADDRESS < 4 || (NUM_ADDRESS & (NUM_ADDRESS - 1)) != 0) begin : g_bad_depth
        $error("NUM_ADDRESS must be a power of two and at least 4");
    end
    if (ALMOST_FULL_THRESHOLD < 1 || ALMOST_FULL_THRESHOLD > NUM_ADDRESS) begin : g_bad_thresh
        $error("ALMOST_FULL_THRESHOLD out of range");
    end

    logic [POINTER_LENGTH-1:0] wbin;
    logic [POINTER_LENGTH-1:0] wbin_next;
    logic [POINTER_LENGTH-1:0] wgray_next;
    logic [POINTER_LENGTH-1:0] rbin_sync;
    logic [POINTER_LENGTH-1:0] full_match;
    logic [POINTER_LENGTH-1:0] level_next;
    logic                      full_next;

    assign write_accept  = write_enable & ~fifo_full;
    assign write_address = wbin[ADDR_WIDTH-1:0];

    fifo_gray_pointer #(
        .WIDTH (POINTER_LENGTH)
    ) u_wptr (
        .clk       (write_clk),
        .reset_n   (write_reset_n),
        .increment (write_accept),
        .bin       (wbin),
        .gray      (write_pointer),
        .bin_next  (wbin_next),
        .gray_next (wgray_next)
    );

    // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    always_comb begin
        full_match = {~read_pointer_sync[POINTER_LENGTH-1:POINTER_LENGTH-2],
                      read_pointer_sync[POINTER_LENGTH-3:0]};
        full_next  = (wgray_next == full_match);
        rbin_sync  = POINTER_LENGTH'(gray2bin(PTR_MAX_W'(read_pointer_sync), POINTER_LENGTH));
        level_next = wbin_next - rbin_sync;
    end

    always_ff @(posedge write_clk) begin
        if (!write_reset_n) begin
            fifo_full   <= 1'b0;
            write_level <= '0;
            overflow    <= 1'b0;
        end else begin
            fifo_full   <= full_next;
            write_level <= level_next;
            overflow    <= overflow | (write_enable & fifo_full);
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    always_ff @(posedge write_clk) begin
        if (!write_reset_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (level_next >= POINTER_LENGTH'(ALMOST_FULL_THRESHOLD));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_pointer_full.sv
// Bench for fifo_write_pointer_full: directed scenarios plus a random run against a write/read count model.
module tb_fifo_write_pointer_full;

    logic       write_clk = 1'b0;
    logic       write_reset_n;
    logic       write_enable;
    logic [3:0] read_pointer_sync;
    logic [3:0] write_pointer;
    logic [2:0] write_address;
    logic       write_accept;
    logic       fifo_full;
    logic [3:0] write_level;
    logic       overflow;
`ifdef FIFO_ALMOST_FULL_EN
    logic       almost_full;
`endif

    always #5 write_clk = ~write_clk;

    fifo_write_pointer_full #(
        .NUM_ADDRESS           (8),
        .ALMOST_FULL_THRESHOLD (6)
    ) dut (
        .write_clk         (write_clk),
        .write_reset_n     (write_reset_n),
        .write_enable      (write_enable),
        .read_pointer_sync (read_pointer_sync),
        .write_pointer     (write_pointer),
        .write_address     (write_address),
        .write_accept      (write_accept),
        .fifo_full         (fifo_full),
        .write_level       (write_level),
        .overflow          (overflow)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .almost_full       (almost_full)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: total accepted writes and reads seen by the writer, as plain integers.
    int  m_w, m_r, m_lvl;
    bit  m_full, m_ovf, m_af;
    bit  seen_acc, exp_acc;
    logic [2:0] seen_addr, exp_addr;

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic model_clear();
        m_w = 0; m_r = 0; m_lvl = 0;
        m_full = 0; m_ovf = 0; m_af = 0;
    endtask

    // One write_clk cycle: drive at negedge, sample strobe/address before the edge, outputs #1 after.
    task automatic step(input bit e, input int rd);
        @(negedge write_clk);
        write_enable      = e;
        m_r               = rd;
        read_pointer_sync = to_gray(rd);
        #1;
        seen_acc  = write_accept;
        seen_addr = write_address;
        exp_acc   = e && !m_full;
        exp_addr  = 3'(m_w % 8);
        @(posedge write_clk);
        if (e && m_full) m_ovf = 1;
        if (exp_acc) m_w++;
        m_lvl  = m_w - m_r;
        m_full = (m_lvl == 8);
        m_af   = (m_lvl >= 6);
        #1;
    endtask

    task automatic test_reset();
        @(negedge write_clk);
        write_reset_n     = 1'b0;
        write_enable      = 1'b1;
        read_pointer_sync = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            @(posedge write_clk);
            #1;
            n_cmp++;
            if (write_pointer !== 4'b0000 || write_address !== 3'd0 || write_level !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_ptr cyc=%0d got wp=%b wa=%0d lvl=%0d exp all 0",
                         c, write_pointer, write_address, write_level);
            end
            n_cmp++;
            if (fifo_full !== 1'b0 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags cyc=%0d got full=%b ovf=%b exp 0 0", c, fifo_full, overflow);
            end
`ifdef FIFO_ALMOST_FULL_EN
            n_cmp++;
            if (almost_full !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_af cyc=%0d got=%b exp=0", c, almost_full);
            end
`endif
        end
        model_clear();
        @(negedge write_clk);
        write_reset_n = 1'b1;
        write_enable  = 1'b0;
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 8; k++) begin
            step(1, 0);
            n_cmp++;
            if (write_pointer !== to_gray(m_w) || write_level !== 4'(m_lvl) || fifo_full !== m_full) begin
                n_fail++;
                $display("FAIL fill_state k=%0d got wp=%b lvl=%0d full=%b exp wp=%b lvl=%0d full=%b",
                         k, write_pointer, write_level, fifo_full, to_gray(m_w), m_lvl, m_full);
            end
`ifdef FIFO_ALMOST_FULL_EN
            n_cmp++;
            if (almost_full !== (k >= 6)) begin
                n_fail++;
                $display("FAIL fill_af k=%0d got=%b exp=%b", k, almost_full, k >= 6);
            end
`endif
        end
        n_cmp++;
        if (write_pointer !== 4'b1100 || write_level !== 4'd8 || fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_end got wp=%b lvl=%0d full=%b exp wp=1100 lvl=8 full=1",
                     write_pointer, write_level, fifo_full);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            step(1, 0);
            n_cmp++;
            if (seen_acc !== 1'b0 || write_pointer !== 4'b1100 || overflow !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_hold k=%0d got acc=%b wp=%b ovf=%b exp acc=0 wp=1100 ovf=1",
                         k, seen_acc, write_pointer, overflow);
            end
        end
        step(0, 0);
        n_cmp++;
        if (overflow !== 1'b1 || write_pointer !== 4'b1100) begin
            n_fail++;
            $display("FAIL ovf_sticky got ovf=%b wp=%b exp ovf=1 wp=1100", overflow, write_pointer);
        end
    endtask

    task automatic test_drain_one();
        step(0, 1);
        n_cmp++;
        if (fifo_full !== 1'b0 || write_level !== 4'd7) begin
            n_fail++;
            $display("FAIL drain_unfull got full=%b lvl=%0d exp full=0 lvl=7", fifo_full, write_level);
        end
        step(1, 1);
        n_cmp++;
        if (seen_acc !== 1'b1 || write_pointer !== 4'b1101 || fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_refill got acc=%b wp=%b full=%b exp acc=1 wp=1101 full=1",
                     seen_acc, write_pointer, fifo_full);
        end
    endtask

    task automatic test_wrap();
        int accepted;
        int guard;
        accepted = 0;
        guard    = 0;
        while (accepted < 16 && guard < 200) begin
            guard++;
            if (m_full) step(0, m_r + 1);
            else if ($urandom_range(0, 3) == 0) step(0, m_r);
            else step(1, m_r);
            if (exp_acc) begin
                n_cmp++;
                if (seen_acc !== 1'b1 || seen_addr !== 3'(accepted % 8)) begin
                    n_fail++;
                    $display("FAIL wrap_addr n=%0d got acc=%b wa=%0d exp acc=1 wa=%0d",
                             accepted, seen_acc, seen_addr, accepted % 8);
                end
                accepted++;
            end
            n_cmp++;
            if (fifo_full !== m_full || write_level !== 4'(m_lvl) || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_flags got full=%b lvl=%0d ovf=%b exp full=%b lvl=%0d ovf=0",
                         fifo_full, write_level, overflow, m_full, m_lvl);
            end
        end
        n_cmp++;
        if (accepted != 16 || write_pointer !== 4'b0000) begin
            n_fail++;
            $display("FAIL wrap_end got accepted=%0d wp=%b exp 16 0000", accepted, write_pointer);
        end
    endtask

    task automatic test_random();
        int rd;
        bit e;
        for (int c = 0; c < 400; c++) begin
            e  = ($urandom_range(0, 99) < 60);
            rd = m_r;
            if (m_r < m_w && $urandom_range(0, 99) < 45) rd = m_r + 1;
            step(e, rd);
            n_cmp++;
            if (seen_acc !== exp_acc || (exp_acc && seen_addr !== exp_addr)) begin
                n_fail++;
                $display("FAIL rnd_accept cyc=%0d got acc=%b wa=%0d exp acc=%b wa=%0d",
                         c, seen_acc, seen_addr, exp_acc, exp_addr);
            end
            n_cmp++;
            if (write_pointer !== to_gray(m_w) || write_address !== 3'(m_w % 8)
                || write_level !== 4'(m_lvl)) begin
                n_fail++;
                $display("FAIL rnd_ptr cyc=%0d got wp=%b wa=%0d lvl=%0d exp wp=%b wa=%0d lvl=%0d",
                         c, write_pointer, write_address, write_level, to_gray(m_w), m_w % 8, m_lvl);
            end
            n_cmp++;
            if (fifo_full !== m_full || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rnd_flags cyc=%0d got full=%b ovf=%b exp full=%b ovf=%b",
                         c, fifo_full, overflow, m_full, m_ovf);
            end
`ifdef FIFO_ALMOST_FULL_EN
            n_cmp++;
            if (almost_full !== m_af) begin
                n_fail++;
                $display("FAIL rnd_af cyc=%0d got=%b exp=%b", c, almost_full, m_af);
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 8; k++) step(1, 0);
        step(1, 0);
        for (int k = 1; k <= 3; k++) step(0, k);
        n_cmp++;
        if (write_level !== 4'd5 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup got lvl=%0d ovf=%b exp lvl=5 ovf=1", write_level, overflow);
        end
        @(negedge write_clk);
        write_reset_n     = 1'b0;
        write_enable      = 1'b1;
        read_pointer_sync = 4'b0000;
        @(posedge write_clk);
        #1;
        n_cmp++;
        if (write_pointer !== 4'd0 || write_address !== 3'd0 || write_level !== 4'd0
            || fifo_full !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear got wp=%b wa=%0d lvl=%0d full=%b ovf=%b exp all 0",
                     write_pointer, write_address, write_level, fifo_full, overflow);
        end
`ifdef FIFO_ALMOST_FULL_EN
        n_cmp++;
        if (almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_af got=%b exp=0", almost_full);
        end
`endif
        model_clear();
        @(negedge write_clk);
        write_reset_n = 1'b1;
        write_enable  = 1'b0;
    endtask

    initial begin
        write_reset_n     = 1'b0;
        write_enable      = 1'b0;
        read_pointer_sync = 4'b0000;
        model_clear();
        test_reset();
        test_fill();
        test_overflow();
        test_drain_one();
        test_reset();
        test_wrap();
        test_reset();
        test_random();
        test_reset();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
